// File: rtl/memtile_delay_pkg.sv
// Shared defaults, channel word type and delay clamp for the memtile variable delay line.
package memtile_delay_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_DEPTH = 512;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

    // Map a requested delay onto the legal range 1..depth.
    function automatic int unsigned clamp_delay(input int unsigned req, input int unsigned depth);
        if (req == 0) begin
            return 1;
        end
        if (req > depth) begin
            return depth;
        end
        return req;
    endfunction

endpackage

// File: rtl/memtile_delay_ram.sv
// Delay storage: one write port, one registered write-first read port (read register is data_out).
module memtile_delay_ram #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 512,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic          rclr,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-address read returns the word being written, so a delay of 1 acts as a plain register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rclr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (we && (raddr == waddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/memtile_var_delay.sv
// Variable-length multi-channel delay line over a circular RAM.
// Optional MEMTILE_DELAY_CHAIN_EN adds cascade input select and mirrored chain outputs.
module memtile_var_delay
    import memtile_delay_pkg::*;
#(
    parameter int unsigned WIDTH         = DEFAULT_WIDTH,
    parameter int unsigned NUM_CH        = 1,
    parameter int unsigned DEPTH         = DEFAULT_DEPTH,
    parameter int unsigned DEFAULT_DELAY = 64,
    localparam int unsigned AW           = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           en,
    input  logic                           cfg_load,
    input  logic [AW:0]                    cfg_delay,
    input  logic [NUM_CH-1:0][WIDTH-1:0]   data_in,
`ifdef MEMTILE_DELAY_CHAIN_EN
    input  logic                           chain_sel,
    input  logic [NUM_CH-1:0][WIDTH-1:0]   chain_data_in,
    output logic [NUM_CH-1:0][WIDTH-1:0]   chain_data_out,
    output logic                           chain_valid_out,
`endif
    output logic [NUM_CH-1:0][WIDTH-1:0]   data_out,
    output logic                           valid_out,
    output logic                           cfg_err
);

    localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW:0] DEFAULT_W = (AW+1)'(DEFAULT_DELAY);

    logic [NUM_CH-1:0][WIDTH-1:0] wr_data;
    logic [NUM_CH*WIDTH-1:0]      rd_data;
    logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_addr;
    logic [AW:0]                  fill_q, fill_d, fill_inc;
    logic [AW:0]                  delay_q, delay_d, delay_m1, cfg_clamped;
    logic                         valid_q, valid_d, err_q, err_d;
    logic                         cfg_bad, wr_en;

`ifdef MEMTILE_DELAY_CHAIN_EN
    assign wr_data         = chain_sel ? chain_data_in : data_in;
    assign chain_data_out  = data_out;
    assign chain_valid_out = valid_q;
`else
    assign wr_data = data_in;
`endif

    assign wr_en       = en & ~flush;
    assign delay_m1    = delay_q - (AW+1)'(1);
    // Output after edge k is the word written D-1 enabled edges before it.
    assign rd_addr     = wr_ptr_q - delay_m1[AW-1:0];
    assign fill_inc    = (fill_q == delay_q) ? fill_q : fill_q + (AW+1)'(1);
    assign cfg_bad     = (cfg_delay == '0) || (cfg_delay > DEPTH_W);
    assign cfg_clamped = (AW+1)'(clamp_delay(32'(cfg_delay), DEPTH));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        valid_d  = valid_q;
        err_d    = err_q;
        delay_d  = delay_q;
        if (flush) begin
            wr_ptr_d = '0;
            fill_d   = '0;
            valid_d  = 1'b0;
            err_d    = 1'b0;
        end else if (en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            fill_d   = fill_inc;
            valid_d  = (fill_inc == delay_q);
        end
        // A new delay restarts the fill so stale-delay samples never show as valid.
        if (cfg_load) begin
            delay_d = cfg_clamped;
            fill_d  = '0;
            valid_d = 1'b0;
            if (cfg_bad) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            delay_q  <= DEFAULT_W;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            delay_q  <= delay_d;
        end
    end

    memtile_delay_ram #(
        .DW    (NUM_CH * WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (wr_en),
        .rclr  (flush),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign data_out  = rd_data;
    assign valid_out = valid_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_memtile_var_delay.sv
// Directed self-checking bench for memtile_var_delay (two channels, default depth and delay).
module tb_memtile_var_delay;

    localparam int W     = 16;
    localparam int NC    = 2;
    localparam int DEPTH = 512;
    localparam int DEF   = 64;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic                 en;
    logic                 cfg_load;
    logic [9:0]           cfg_delay;
    logic [NC-1:0][W-1:0] data_in;
    logic [NC-1:0][W-1:0] data_out;
    logic                 valid_out;
    logic                 cfg_err;

    int tests;
    int fails;

    always #5 clk = ~clk;

    memtile_var_delay #(
        .WIDTH         (W),
        .NUM_CH        (NC),
        .DEPTH         (DEPTH),
        .DEFAULT_DELAY (DEF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .en        (en),
        .cfg_load  (cfg_load),
        .cfg_delay (cfg_delay),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .cfg_err   (cfg_err)
    );

    // Channel 1 carries a scrambled copy of channel 0.
    function automatic logic [NC-1:0][W-1:0] mk(input int v);
        logic [W-1:0] x;
        x  = W'(v);
        mk = {x ^ 16'hA5A5, x};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_delay(input int d);
        en        = 1'b0;
        cfg_delay = 10'(d);
        cfg_load  = 1'b1;
        tick();
        cfg_load  = 1'b0;
    endtask

    task automatic test_reset();
        flush = 1'b0; en = 1'b0; cfg_load = 1'b0; cfg_delay = '0; data_in = '0;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        tests++;
        if (valid_out !== 1'b0) begin
            fails++; $display("FAIL reset_valid got %b want 0", valid_out);
        end
        tests++;
        if (data_out !== mk(0) && data_out !== '0) begin
            fails++; $display("FAIL reset_data got %h want 0", data_out);
        end
        tests++;
        if (cfg_err !== 1'b0) begin
            fails++; $display("FAIL reset_err got %b want 0", cfg_err);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (valid_out !== 1'b0 || data_out !== '0) begin
            fails++; $display("FAIL reset_release got v=%b d=%h want v=0 d=0", valid_out, data_out);
        end
    endtask

    task automatic test_default_delay();
        en = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            data_in = mk(k);
            tick();
            tests++;
            if (valid_out !== (k >= DEF)) begin
                fails++; $display("FAIL dflt_valid k=%0d got %b want %b", k, valid_out, k >= DEF);
            end
            if (k >= DEF) begin
                tests++;
                if (data_out !== mk(k - DEF + 1)) begin
                    fails++; $display("FAIL dflt_data k=%0d got %h want %h", k, data_out, mk(k - DEF + 1));
                end
            end
        end
        en      = 1'b0;
        data_in = mk(999);
        tick();
        tests++;
        if (valid_out !== 1'b1 || data_out !== mk(7)) begin
            fails++; $display("FAIL dflt_hold got v=%b d=%h want v=1 d=%h", valid_out, data_out, mk(7));
        end
    endtask

    task automatic test_delay_one();
        load_delay(1);
        tests++;
        if (valid_out !== 1'b0 || cfg_err !== 1'b0) begin
            fails++; $display("FAIL d1_load got v=%b e=%b want v=0 e=0", valid_out, cfg_err);
        end
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            data_in = mk(100 + k);
            tick();
            tests++;
            if (valid_out !== 1'b1 || data_out !== mk(100 + k)) begin
                fails++; $display("FAIL d1_data k=%0d got v=%b d=%h want v=1 d=%h",
                                  k, valid_out, data_out, mk(100 + k));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_clamp();
        load_delay(0);
        tests++;
        if (cfg_err !== 1'b1) begin
            fails++; $display("FAIL clamp0_err got %b want 1", cfg_err);
        end
        en      = 1'b1;
        data_in = mk(40);
        tick();
        tests++;
        if (valid_out !== 1'b1 || data_out !== mk(40)) begin
            fails++; $display("FAIL clamp0_d1 got v=%b d=%h want v=1 d=%h", valid_out, data_out, mk(40));
        end
        load_delay(DEPTH + 5);
        tests++;
        if (cfg_err !== 1'b1 || valid_out !== 1'b0) begin
            fails++; $display("FAIL clamphi_load got e=%b v=%b want e=1 v=0", cfg_err, valid_out);
        end
        en = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            data_in = mk(1000 + k);
            tick();
            if (k == DEPTH - 1) begin
                tests++;
                if (valid_out !== 1'b0) begin
                    fails++; $display("FAIL clamphi_early got v=%b want 0", valid_out);
                end
            end
            if (k == DEPTH) begin
                tests++;
                if (valid_out !== 1'b1 || data_out !== mk(1001) || cfg_err !== 1'b1) begin
                    fails++; $display("FAIL clamphi_full got v=%b d=%h e=%b want v=1 d=%h e=1",
                                      valid_out, data_out, cfg_err, mk(1001));
                end
            end
        end
        en    = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests++;
        if (cfg_err !== 1'b0 || valid_out !== 1'b0 || data_out !== '0) begin
            fails++; $display("FAIL flush_clear got e=%b v=%b d=%h want e=0 v=0 d=0",
                              cfg_err, valid_out, data_out);
        end
    endtask

    task automatic test_wrap();
        en = 1'b1;
        for (int k = 1; k <= 3 * DEPTH; k++) begin
            data_in = mk(k);
            tick();
            tests++;
            if (valid_out !== (k >= DEPTH)) begin
                fails++; $display("FAIL wrap_valid k=%0d got %b want %b", k, valid_out, k >= DEPTH);
            end
            if (k >= DEPTH) begin
                tests++;
                if (data_out !== mk(k - DEPTH + 1)) begin
                    fails++; $display("FAIL wrap_data k=%0d got %h want %h",
                                      k, data_out, mk(k - DEPTH + 1));
                end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_en_random();
        int n;
        logic exp_v;
        logic [NC-1:0][W-1:0] exp_d;
        logic e;
        load_delay(10);
        n     = 0;
        exp_v = 1'b0;
        exp_d = '0;
        for (int i = 0; i < 300; i++) begin
            e       = 1'($urandom_range(0, 1));
            en      = e;
            data_in = e ? mk(5000 + n + 1) : mk(16'hDEAD);
            tick();
            if (e) begin
                n++;
                exp_v = (n >= 10);
                if (exp_v) exp_d = mk(5000 + n - 9);
            end
            tests++;
            if (valid_out !== exp_v) begin
                fails++; $display("FAIL rnd_valid i=%0d got %b want %b", i, valid_out, exp_v);
            end
            if (exp_v) begin
                tests++;
                if (data_out !== exp_d) begin
                    fails++; $display("FAIL rnd_data i=%0d got %h want %h", i, data_out, exp_d);
                end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_flush();
        load_delay(64);
        en = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            data_in = mk(200 + k);
            tick();
        end
        flush   = 1'b1;
        data_in = mk(16'hBEEF);
        tick();
        flush = 1'b0;
        tests++;
        if (valid_out !== 1'b0 || data_out !== '0) begin
            fails++; $display("FAIL flush_edge got v=%b d=%h want v=0 d=0", valid_out, data_out);
        end
        for (int k = 1; k <= 70; k++) begin
            data_in = mk(300 + k);
            tick();
            tests++;
            if (valid_out !== (k >= 64)) begin
                fails++; $display("FAIL flush_valid k=%0d got %b want %b", k, valid_out, k >= 64);
            end
            if (k >= 64) begin
                tests++;
                if (data_out !== mk(300 + k - 63)) begin
                    fails++; $display("FAIL flush_data k=%0d got %h want %h", k, data_out, mk(300 + k - 63));
                end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid();
        load_delay(5);
        en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            data_in = mk(700 + k);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (valid_out !== 1'b0 || data_out !== '0) begin
            fails++; $display("FAIL midrst_async got v=%b d=%h want v=0 d=0", valid_out, data_out);
        end
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        en    = 1'b1;
        for (int k = 1; k <= DEF; k++) begin
            data_in = mk(800 + k);
            tick();
            tests++;
            if (valid_out !== (k >= DEF)) begin
                fails++; $display("FAIL midrst_valid k=%0d got %b want %b", k, valid_out, k >= DEF);
            end
        end
        tests++;
        if (data_out !== mk(801)) begin
            fails++; $display("FAIL midrst_data got %h want %h", data_out, mk(801));
        end
        en = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_default_delay();
        test_delay_one();
        test_clamp();
        test_wrap();
        test_en_random();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
